// File: rtl/window_frame_ctrl_if.sv
// Sample-in / frame-out bundle between the ADC front end, this controller and the
// window multiplier. The controller uses the slave modport.
interface window_frame_ctrl_if #(
  parameter int unsigned SAMPLE_BITS = 12,
  parameter int unsigned WINDOW_SIZE = 128
);
  localparam int unsigned ADDR_BITS = $clog2(WINDOW_SIZE);

  logic                   in_valid;
  logic [SAMPLE_BITS-1:0] in_sample;
  logic                   frame_ready;
  logic [ADDR_BITS-1:0]   win_addr;
  logic [SAMPLE_BITS-1:0] out_sample;
  logic                   out_valid;
  logic                   out_first;
  logic                   out_last;
  logic                   overrun;
  logic [15:0]            frame_count;

  modport slave (
    input  in_valid, in_sample, frame_ready,
    output win_addr, out_sample, out_valid, out_first, out_last, overrun, frame_count
  );

  modport master (
    output in_valid, in_sample, frame_ready,
    input  win_addr, out_sample, out_valid, out_first, out_last, overrun, frame_count
  );
endinterface

// File: rtl/window_frame_ctrl.sv
// Buffers ADC samples in a 2W circular RAM and streams the newest WINDOW_SIZE samples
// oldest-first, with the window ROM address kept in lock-step with the RAM read.
module window_frame_ctrl #(
  parameter int unsigned SAMPLE_BITS = 12,
  parameter int unsigned WINDOW_SIZE = 128,
  parameter int unsigned HOP_SIZE    = 64
) (
  input  logic                clk,
  input  logic                rst,
  window_frame_ctrl_if.slave  bus
);
  localparam int unsigned IDX_BITS = $clog2(WINDOW_SIZE);
  localparam int unsigned PTR_BITS = IDX_BITS + 1;
  localparam int unsigned DEPTH    = 2 * WINDOW_SIZE;
  localparam int unsigned CNT_BITS = $clog2(WINDOW_SIZE + 1);
  localparam int unsigned HOP_BITS = $clog2(HOP_SIZE + 1);

  typedef enum logic [1:0] {S_FILL, S_IDLE, S_WAIT, S_STREAM} state_t;

  state_t                 state, state_nxt;
  logic [PTR_BITS-1:0]    wr_ptr;
  logic [CNT_BITS-1:0]    fill_cnt;
  logic [HOP_BITS-1:0]    hop_cnt;
  logic [PTR_BITS-1:0]    rd_base, rd_base_nxt;
  logic [IDX_BITS-1:0]    idx, idx_nxt;
  logic                   pending, pending_nxt;
  logic                   overrun_q, overrun_nxt;
  logic [15:0]            frame_cnt, frame_cnt_nxt;
  logic                   valid_q, first_q, last_q;
  logic [SAMPLE_BITS-1:0] rd_data;
  logic [SAMPLE_BITS-1:0] mem [DEPTH];

  logic                   filled, fill_last, hop_hit, trigger, streaming, idx_last;
  logic [PTR_BITS-1:0]    rd_ptr;

  assign filled    = (fill_cnt == CNT_BITS'(WINDOW_SIZE));
  assign fill_last = (fill_cnt == CNT_BITS'(WINDOW_SIZE - 1));
  assign hop_hit   = (HOP_BITS'(hop_cnt + 1'b1) == HOP_BITS'(HOP_SIZE));
  assign trigger   = bus.in_valid && (fill_last || (filled && hop_hit));
  assign streaming = (state == S_STREAM);
  assign idx_last  = (idx == IDX_BITS'(WINDOW_SIZE - 1));
  assign rd_ptr    = PTR_BITS'(rd_base + PTR_BITS'(idx));

  // Write side: pointer, fill level and hop counter (hop held at 0 until full)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
      hop_cnt  <= '0;
    end else if (bus.in_valid) begin
      wr_ptr <= PTR_BITS'(wr_ptr + 1'b1);
      if (!filled) begin
        fill_cnt <= CNT_BITS'(fill_cnt + 1'b1);
      end else if (hop_hit) begin
        hop_cnt <= '0;
      end else begin
        hop_cnt <= HOP_BITS'(hop_cnt + 1'b1);
      end
    end
  end

  // Sample RAM; contents survive reset
  always_ff @(posedge clk) begin
    if (!rst && bus.in_valid) begin
      mem[wr_ptr] <= bus.in_sample;
    end
  end

  // Registered read port, same latency as the window ROM
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (streaming) begin
      rd_data <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FILL;
      rd_base   <= '0;
      idx       <= '0;
      pending   <= 1'b0;
      overrun_q <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_nxt;
      rd_base   <= rd_base_nxt;
      idx       <= idx_nxt;
      pending   <= pending_nxt;
      overrun_q <= overrun_nxt;
      frame_cnt <= frame_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    rd_base_nxt   = rd_base;
    idx_nxt       = idx;
    pending_nxt   = pending;
    overrun_nxt   = overrun_q;
    frame_cnt_nxt = frame_cnt;
    case (state)
      S_FILL, S_IDLE: begin
        if (trigger) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // Frame base includes a sample written in this very cycle
        if (bus.frame_ready) begin
          state_nxt   = S_STREAM;
          idx_nxt     = '0;
          rd_base_nxt = PTR_BITS'(wr_ptr + PTR_BITS'(bus.in_valid) - PTR_BITS'(WINDOW_SIZE));
        end
      end
      S_STREAM: begin
        idx_nxt = IDX_BITS'(idx + 1'b1);
        if (trigger && pending) overrun_nxt = 1'b1;
        if (idx_last) begin
          state_nxt     = (pending || trigger) ? S_WAIT : S_IDLE;
          pending_nxt   = 1'b0;
          idx_nxt       = '0;
          frame_cnt_nxt = 16'(frame_cnt + 16'd1);
        end else if (trigger) begin
          pending_nxt = 1'b1;
        end
      end
      default: state_nxt = S_FILL;
    endcase
  end

  // Stream qualifiers delayed one stage to line up with RAM/ROM data
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= streaming;
      first_q <= streaming && (idx == '0);
      last_q  <= streaming && idx_last;
    end
  end

  assign bus.win_addr    = streaming ? idx : '0;
  assign bus.out_sample  = rd_data;
  assign bus.out_valid   = valid_q;
  assign bus.out_first   = first_q;
  assign bus.out_last    = last_q;
  assign bus.overrun     = overrun_q;
  assign bus.frame_count = frame_cnt;
endmodule
